// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave in front of a single-port, word-addressed SRAM.
// The write and read channels are independent; a write commit owns the array for its cycle.
module axi4lite_sram_slave #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AWdata,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [2:0]  AWprot,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    input  logic        Wvalid,
    output logic        Wready,
    output logic        Bvalid,
    input  logic        Bready,
    input  logic [31:0] ARdata,
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [2:0]  ARprot,
    output logic [31:0] Rdata,
    output logic        Rvalid,
    input  logic        RReady
);

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic              aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
    logic              b_valid_q, b_valid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem [2**ADDR_W];
    logic              commit;
    logic              unused_ok;

    assign commit = (w_state_q == W_COMMIT);

    // NOTE: every signal gets its default first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (AWvalid && aw_ready_q) begin
                    aw_held_d = 1'b1;
                    waddr_d   = AWdata[ADDR_W+1:2];
                end
                if (Wvalid && w_ready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = Wdata;
                    wstrb_d  = Wstrb;
                end
                aw_ready_d = !aw_held_d;
                w_ready_d  = !w_held_d;
                if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
            end
            W_COMMIT: begin
                w_state_d = W_RESP;
                b_valid_d = 1'b1;
            end
            W_RESP: begin
                if (Bready) begin
                    w_state_d  = W_IDLE;
                    b_valid_d  = 1'b0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    aw_ready_d = 1'b1;
                    w_ready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // A read in R_ACCESS simply retries while the write side holds the array.
    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                if (ARvalid && ar_ready_q) begin
                    raddr_d    = ARdata[ADDR_W+1:2];
                    ar_ready_d = 1'b0;
                    r_state_d  = R_ACCESS;
                end
            end
            R_ACCESS: begin
                if (!commit) begin
                    rdata_d   = mem[raddr_q];
                    r_valid_d = 1'b1;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (RReady) begin
                    r_valid_d  = 1'b0;
                    ar_ready_d = 1'b1;
                    r_state_d  = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            raddr_q    <= '0;
            rdata_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
        end
    end

    // NOTE: the array has no reset; an aborted commit is blocked because reset clears w_state_q.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[waddr_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign AWready = aw_ready_q;
    assign Wready  = w_ready_q;
    assign Bvalid  = b_valid_q;
    assign ARready = ar_ready_q;
    assign Rvalid  = r_valid_q;
    assign Rdata   = rdata_q;

    assign unused_ok = ^{AWprot, ARprot, AWdata[31:ADDR_W+2], AWdata[1:0],
                         ARdata[31:ADDR_W+2], ARdata[1:0]};

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Directed and randomized bench for axi4lite_sram_slave, checked against a word-array reference model.
module tb_axi4lite_sram_slave;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AWdata, Wdata, ARdata, Rdata;
    logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
    logic        ARvalid, ARready, Rvalid, RReady;
    logic [2:0]  AWprot, ARprot;
    logic [3:0]  Wstrb;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];

    axi4lite_sram_slave #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .AWdata(AWdata), .AWvalid(AWvalid), .AWready(AWready), .AWprot(AWprot),
        .Wdata(Wdata), .Wstrb(Wstrb), .Wvalid(Wvalid), .Wready(Wready),
        .Bvalid(Bvalid), .Bready(Bready),
        .ARdata(ARdata), .ARvalid(ARvalid), .ARready(ARready), .ARprot(ARprot),
        .Rdata(Rdata), .Rvalid(Rvalid), .RReady(RReady)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k = widx(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[k][8*b +: 8] = d[8*b +: 8];
        if (s == 4'hF) ref_known[k] = 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, " outs"}, {27'd0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'd0);
        check({tag, " rdata"}, Rdata, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        @(negedge clk);
        AWdata = a; Wdata = d; Wstrb = s; AWvalid = 1'b1; Wvalid = 1'b1; Bready = 1'b1;
        for (int t = 0; t < 20 && !(AWready && Wready); t++) @(negedge clk);
        check({tag, " aw/w ready"}, 32'(AWready && Wready), 32'd1);
        @(negedge clk);
        AWvalid = 1'b0; Wvalid = 1'b0; AWdata = $urandom; Wdata = $urandom; Wstrb = 4'($urandom);
        ref_write(a, d, s);
        check({tag, " no early B"}, {30'd0, Bvalid, AWready}, 32'd0);
        @(negedge clk);
        check({tag, " bvalid"}, 32'(Bvalid), 32'd1);
        @(negedge clk);
        check({tag, " B done"}, {29'd0, Bvalid, AWready, Wready}, 32'b011);
    endtask

    task automatic do_read(input logic [31:0] a, input string tag, output logic [31:0] got);
        @(negedge clk);
        ARdata = a; ARvalid = 1'b1; RReady = 1'b1;
        for (int t = 0; t < 20 && !ARready; t++) @(negedge clk);
        check({tag, " ar ready"}, 32'(ARready), 32'd1);
        @(negedge clk);
        ARvalid = 1'b0; ARdata = $urandom;
        check({tag, " no early R"}, {30'd0, Rvalid, ARready}, 32'd0);
        @(negedge clk);
        check({tag, " rvalid"}, 32'(Rvalid), 32'd1);
        check({tag, " rdata"}, Rdata, ref_mem[widx(a)]);
        got = Rdata;
        @(negedge clk);
        check({tag, " R done"}, {30'd0, Rvalid, ARready}, 32'b01);
    endtask

    // Write and read handshake on the same edge: the read sees the write's result one cycle late.
    task automatic do_both(input logic [31:0] wa, input logic [31:0] d, input logic [3:0] s,
                           input logic [31:0] ra, input string tag);
        @(negedge clk);
        AWdata = wa; Wdata = d; Wstrb = s; ARdata = ra;
        AWvalid = 1'b1; Wvalid = 1'b1; ARvalid = 1'b1; Bready = 1'b1; RReady = 1'b1;
        for (int t = 0; t < 20 && !(AWready && Wready && ARready); t++) @(negedge clk);
        check({tag, " all ready"}, 32'(AWready && Wready && ARready), 32'd1);
        @(negedge clk);
        AWvalid = 1'b0; Wvalid = 1'b0; ARvalid = 1'b0;
        ref_write(wa, d, s);
        check({tag, " k"}, {30'd0, Bvalid, Rvalid}, 32'd0);
        @(negedge clk);
        check({tag, " stall"}, {30'd0, Bvalid, Rvalid}, 32'b10);
        @(negedge clk);
        check({tag, " rvalid"}, {30'd0, Bvalid, Rvalid}, 32'b01);
        check({tag, " rdata"}, Rdata, ref_mem[widx(ra)]);
        @(negedge clk);
        check({tag, " done"}, {29'd0, Rvalid, ARready, AWready}, 32'b011);
    endtask

    task automatic split_write(input bit aw_first, input logic [31:0] a, input logic [31:0] d, input string tag);
        @(negedge clk);
        Bready = 1'b1;
        AWdata = a; Wdata = d; Wstrb = 4'hF;
        if (aw_first) AWvalid = 1'b1; else Wvalid = 1'b1;
        for (int t = 0; t < 20 && !(aw_first ? AWready : Wready); t++) @(negedge clk);
        check({tag, " first ready"}, 32'(aw_first ? AWready : Wready), 32'd1);
        @(negedge clk);
        AWvalid = 1'b0; Wvalid = 1'b0;
        check({tag, " readies"}, {30'd0, AWready, Wready}, aw_first ? 32'b01 : 32'b10);
        @(negedge clk);
        check({tag, " no B 1"}, 32'(Bvalid), 32'd0);
        @(negedge clk);
        check({tag, " no B 2"}, 32'(Bvalid), 32'd0);
        if (aw_first) Wvalid = 1'b1; else AWvalid = 1'b1;
        @(negedge clk);
        AWvalid = 1'b0; Wvalid = 1'b0;
        ref_write(a, d, 4'hF);
        check({tag, " no B 3"}, {29'd0, Bvalid, AWready, Wready}, 32'd0);
        @(negedge clk);
        check({tag, " bvalid"}, 32'(Bvalid), 32'd1);
        @(negedge clk);
        check({tag, " B end"}, 32'(Bvalid), 32'd0);
        @(negedge clk);
        check({tag, " single B"}, {29'd0, Bvalid, AWready, Wready}, 32'b011);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] exp_r;
        rst = 1'b1;
        AWdata = '0; AWvalid = 1'b0; AWprot = '0; Wdata = '0; Wstrb = '0; Wvalid = 1'b0;
        Bready = 1'b0; ARdata = '0; ARvalid = 1'b0; ARprot = '0; RReady = 1'b0;

        // Reset state and readies rising on the first edge after release.
        repeat (3) @(negedge clk);
        check_all_low("reset");
        rst = 1'b0;
        check({"pre-edge"}, {29'd0, AWready, Wready, ARready}, 32'd0);
        @(negedge clk);
        check({"post-reset"}, {27'd0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'b11100);

        // Full write then read.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, "full wr");
        do_read(32'h10, "full rd", got);
        check("full value", got, 32'hDEADBEEF);

        // Partial strobes, including an empty strobe that must still give a B.
        do_write(32'h20, 32'h11223344, 4'hF, "part init");
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, "part wr");
        do_read(32'h20, "part rd", got);
        check("part value", got, 32'h11BB33DD);
        do_write(32'h20, 32'hFFFFFFFF, 4'b0000, "strb0 wr");
        do_read(32'h20, "strb0 rd", got);
        check("strb0 value", got, 32'h11BB33DD);

        // AW leading W and W leading AW.
        split_write(1'b1, 32'h80, 32'h01020304, "aw first");
        do_read(32'h80, "aw first rd", got);
        split_write(1'b0, 32'h84, 32'hA0B0C0D0, "w first");
        do_read(32'h84, "w first rd", got);
        check("w first value", got, 32'hA0B0C0D0);

        // Read/write collision on the same address.
        do_write(32'h40, 32'h0, 4'hF, "coll init");
        do_both(32'h40, 32'h55AA55AA, 4'hF, 32'h40, "collision");

        // Backpressure on both response channels.
        @(negedge clk);
        AWdata = 32'h200; Wdata = 32'h76543210; Wstrb = 4'hF; AWvalid = 1'b1; Wvalid = 1'b1; Bready = 1'b0;
        for (int t = 0; t < 20 && !(AWready && Wready); t++) @(negedge clk);
        check("bp aw/w ready", 32'(AWready && Wready), 32'd1);
        @(negedge clk);
        AWvalid = 1'b0; Wvalid = 1'b0;
        ref_write(32'h200, 32'h76543210, 4'hF);
        @(negedge clk);
        check("bp bvalid", 32'(Bvalid), 32'd1);
        ARdata = 32'h20; ARvalid = 1'b1; RReady = 1'b0;
        @(negedge clk);
        ARvalid = 1'b0;
        @(negedge clk);
        exp_r = ref_mem[widx(32'h20)];
        for (int i = 0; i < 5; i++) begin
            ARdata = $urandom; Wdata = $urandom;
            check("bp valids", {30'd0, Bvalid, Rvalid}, 32'b11);
            check("bp rdata", Rdata, exp_r);
            check("bp readies", {29'd0, AWready, Wready, ARready}, 32'd0);
            @(negedge clk);
        end
        Bready = 1'b1; RReady = 1'b1;
        @(negedge clk);
        check("bp release", {27'd0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'b11100);

        // Address wrap.
        do_write(32'h1004, 32'h5A5A1234, 4'hF, "wrap wr");
        do_read(32'h0004, "wrap rd", got);
        check("wrap value", got, 32'h5A5A1234);

        // Reset during the commit cycle must not write the array.
        do_write(32'h300, 32'hCAFEF00D, 4'hF, "abort init");
        @(negedge clk);
        AWdata = 32'h300; Wdata = 32'h0BADBEEF; Wstrb = 4'hF; AWvalid = 1'b1; Wvalid = 1'b1;
        for (int t = 0; t < 20 && !(AWready && Wready); t++) @(negedge clk);
        check("abort ready", 32'(AWready && Wready), 32'd1);
        @(negedge clk);
        AWvalid = 1'b0; Wvalid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_low("abort commit");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort readies", {27'd0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'b11100);
        do_read(32'h300, "abort rd", got);

        // Reset while write is in W_RESP and read is in R_ACCESS.
        @(negedge clk);
        AWdata = 32'h340; Wdata = 32'h13579BDF; Wstrb = 4'hF; AWvalid = 1'b1; Wvalid = 1'b1; Bready = 1'b0;
        for (int t = 0; t < 20 && !(AWready && Wready); t++) @(negedge clk);
        check("mid ready", 32'(AWready && Wready), 32'd1);
        @(negedge clk);
        AWvalid = 1'b0; Wvalid = 1'b0;
        ref_write(32'h340, 32'h13579BDF, 4'hF);
        @(negedge clk);
        check("mid bvalid", 32'(Bvalid), 32'd1);
        ARdata = 32'h10; ARvalid = 1'b1; RReady = 1'b1;
        @(negedge clk);
        ARvalid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_low("mid reset");
        @(negedge clk);
        check_all_low("mid held");
        Bready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("mid readies", {27'd0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'b11100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid no stale", {30'd0, Bvalid, Rvalid}, 32'd0);
        end
        do_read(32'h340, "mid rd", got);

        // Randomized traffic over a small word pool with random upper and byte-offset address bits.
        for (int n = 0; n < 40; n++) begin
            int          op;
            int          wi, ri;
            logic [31:0] wa, ra, d;
            logic [3:0]  s;
            op = int'($urandom_range(0, 2));
            wi = 32'h380 + int'($urandom_range(0, 15));
            ri = 32'h380 + int'($urandom_range(0, 15));
            wa = ($urandom & 32'hFFFF_F000) | (32'(wi) << 2) | ($urandom & 32'h3);
            ra = ($urandom & 32'hFFFF_F000) | (32'(ri) << 2) | ($urandom & 32'h3);
            d  = $urandom;
            s  = ref_known[wi] ? 4'($urandom) : 4'hF;
            if (op == 0 || !ref_known[ri]) begin
                do_write(wa, d, s, "rnd wr");
            end else if (op == 1) begin
                do_read(ra, "rnd rd", got);
            end else begin
                if (!ref_known[wi]) s = 4'hF;
                do_both(wa, d, s, ra, "rnd both");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4lite_sram_slave.md
# axi4lite_sram_slave

Word-addressed synchronous SRAM exposed as an AXI4-Lite slave. It sits directly downstream of the core's memory interface, on the load/store bus, and consumes the AW/W/B and AR/R channel traffic the core emits. Independent read and write channels share one single-port array, with writes given priority on collision. No response codes are generated; the core's bus carries none.

## Interface
- `ADDR_W`, default 10: word-index width; the array holds 2^ADDR_W 32-bit words.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `AWdata` input 32: write byte address.
- `AWvalid` input 1: write address valid.
- `AWready` output 1: write address accepted.
- `AWprot` input 3: ignored.
- `Wdata` input 32: write data.
- `Wstrb` input 4: byte enables; bit i enables `Wdata[8i+7:8i]`.
- `Wvalid` input 1: write data valid.
- `Wready` output 1: write data accepted.
- `Bvalid` output 1: write complete.
- `Bready` input 1: master accepts the write completion.
- `ARdata` input 32: read byte address.
- `ARvalid` input 1: read address valid.
- `ARready` output 1: read address accepted.
- `ARprot` input 3: ignored.
- `Rdata` output 32: read data.
- `Rvalid` output 1: read data valid.
- `RReady` input 1: master accepts the read data.

## Operation
- Word index is `addr[ADDR_W+1:2]`. Bits [1:0] and the bits above ADDR_W+1 are ignored, so addresses wrap modulo the array size. Array contents are not reset.
- **Write channel.** The AW and W channels are captured independently into holding registers, in either order or in the same cycle.
  - `AWready` is 1 while no address is held and no B is pending; `Wready` follows the same rule for data.
  - Once both are held, the next cycle is the commit cycle. Only the bytes whose `Wstrb` bit is set are written; a strobe of 4'b0000 writes nothing but still produces a B.
  - `Bvalid` is set after the commit edge and held until the `Bvalid & Bready` edge. On that edge the holding registers clear and both readies return to 1.
- **Read channel.** On an AR handshake the address is latched and `ARready` drops to 0.
  - The array is read on the next edge, unless that edge is a write commit. In that case the read waits exactly one cycle.
  - `Rvalid` is set together with `Rdata`. `Rdata` stays stable until the `Rvalid & RReady` edge, after which `ARready` returns to 1.
- **Priority.** The write commit owns the array on a collision. A read of an address being committed in the same cycle is stalled, so it returns the new data, merged per the strobes.
- **Protocol rules.**
  - One outstanding transaction per channel.
  - A valid signal held high without a ready is simply waited on.
  - Payloads are sampled only on handshake edges; changes while not ready are ignored.

## Timing
- Reset values: `AWready`, `Wready`, `ARready`, `Bvalid`, `Rvalid` = 0, and `Rdata` = 0. All internal holding state is cleared.
- All outputs are registered. Readies rise on the first clock edge after `rst` falls.
- Reset asserted mid-transaction aborts it. A commit that has not yet reached its edge does not write, and no B or R is produced afterwards.
- Write latency: with AW and W handshakes complete at edge k, the array is written at edge k+1 and `Bvalid` = 1 after edge k+1. With `Bready` held 1, the next AW/W can be accepted at edge k+3.
- Read latency: AR handshake at edge k gives `Rvalid` after edge k+1, or after k+2 if edge k+1 is a write commit. With `RReady` held 1, the next AR is accepted at edge k+3.
- States, per channel:
  - Write: W_IDLE (waiting for AW and W) → W_COMMIT (one cycle) → W_RESP (`Bvalid`, until `Bready`) → W_IDLE.
  - Read: R_IDLE → R_ACCESS (one cycle, repeated while stalled) → R_RESP (`Rvalid`, until `RReady`) → R_IDLE.

## Test plan
- **Full write, then read.** After reset, write 0xDEADBEEF to 0x10 with `Wstrb` = 4'hF, then read 0x10. Expect `Bvalid` 1 cycle after the combined handshake, then `Rvalid` 1 cycle after AR with `Rdata` = 0xDEADBEEF.
- **Partial strobe.** With 0x11223344 stored at 0x20, write 0xAABBCCDD with `Wstrb` = 4'b0101. A read then returns 0x11BB33DD.
- **Split AW/W.** Present AW three cycles before W, then repeat with W three cycles before AW. In both cases the commit happens the cycle after the later handshake, exactly one B is produced, and data is correct.
- **Collision.** AR for 0x40 is accepted on the same edge that AW/W for 0x40 complete, carrying 0x55AA55AA. The read stalls one cycle; `Rvalid` comes 2 cycles after AR with `Rdata` = 0x55AA55AA.
- **Backpressure and wrap.** Hold `Bready` and `RReady` at 0 for 5 cycles: `Bvalid`/`Rvalid` and `Rdata` stay stable and all readies stay 0. With ADDR_W = 10, a write to 0x1004 is readable at 0x0004.
- **Reset mid-operation.** Assert `rst` during W_RESP and R_ACCESS. All outputs go to 0 immediately; after release, the readies return and no stale B or R appears.
